// File: rtl/mem_arbiter_if.sv
// Shared memory port bundle: icache and dcache request/response plus the single RAM port.
// The arbiter takes the slave side; the cache/RAM environment takes the master side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between icache and dcache. Dcache wins contention until the
// icache has lost STARVE_MAX times; a dcache block (two words) is never interleaved.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [2:0] SMAX       = 3'(STARVE_MAX);

    state_t     state, state_n;
    logic [2:0] scnt, scnt_n;
    logic       d_req;
    logic       access;

    assign d_req  = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            scnt  <= 3'd0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        case (state)
            IDLE: begin
                if (bus.iREN && d_req) begin
                    if (scnt >= SMAX) begin
                        state_n = IGNT;
                    end else begin
                        state_n = DGNT;
                        scnt_n  = (scnt == 3'd7) ? 3'd7 : scnt + 3'd1;
                    end
                end else if (bus.iREN) begin
                    state_n = IGNT;
                end else if (d_req) begin
                    state_n = DGNT;
                end
            end
            IGNT: begin
                if (!bus.iREN || access) state_n = IDLE;
            end
            DGNT: begin
                // First word of a block (daddr[2]==0) keeps the grant for the second word.
                if (!d_req) state_n = IDLE;
                else if (access && bus.daddr[2]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IGNT && state != IGNT) scnt_n = 3'd0;
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;
        case (state)
            IGNT: begin
                // Strobes follow the live request so an abort drops them immediately.
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = ~(bus.iREN & access);
                bus.iload   = bus.ramload;
            end
            DGNT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = ~(d_req & access);
                bus.dload    = bus.ramload;
            end
            default: ;
        endcase
    end
endmodule
